// File: rtl/mem_access_pkg.sv
// Shared constants for mem_access_unit: RV32E load/store funct3 codes,
// FSM state encoding and the num_bytes values driven to mem_controller.
package mem_access_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [2:0] NB_BYTE = 3'd1;
   localparam logic [2:0] NB_HALF = 3'd2;
   localparam logic [2:0] NB_WORD = 3'd4;

   typedef struct packed {
      logic [2:0] num_bytes;
      logic       misaligned;
      logic       illegal;
   } req_decode_t;

endpackage

// File: rtl/mem_access_align.sv
// Combinational request decode (size, alignment, funct3 legality) and
// load-data extension for mem_access_unit.
module mem_access_align
   import mem_access_pkg::*;
(
   input  logic        i_is_fetch,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   output logic [2:0]  o_num_bytes,
   output logic        o_misaligned,
   output logic        o_illegal,
   input  logic        i_rd_is_fetch,
   input  logic [2:0]  i_rd_funct3,
   input  logic [31:0] i_rd_raw,
   output logic [31:0] o_rd_data
);

   req_decode_t w_dec;

   always_comb begin
      w_dec = '{num_bytes: NB_WORD, misaligned: 1'b0, illegal: 1'b0};
      if (i_is_fetch) begin
         w_dec.misaligned = |i_addr_lo;
      end else if (i_is_store) begin
         case (i_funct3)
            F3_SB: w_dec.num_bytes = NB_BYTE;
            F3_SH: begin
               w_dec.num_bytes  = NB_HALF;
               w_dec.misaligned = i_addr_lo[0];
            end
            F3_SW:   w_dec.misaligned = |i_addr_lo;
            default: w_dec.illegal    = 1'b1;
         endcase
      end else begin
         case (i_funct3)
            F3_LB, F3_LBU: w_dec.num_bytes = NB_BYTE;
            F3_LH, F3_LHU: begin
               w_dec.num_bytes  = NB_HALF;
               w_dec.misaligned = i_addr_lo[0];
            end
            F3_LW:   w_dec.misaligned = |i_addr_lo;
            default: w_dec.illegal    = 1'b1;
         endcase
      end
   end

   assign o_num_bytes  = w_dec.num_bytes;
   assign o_misaligned = w_dec.misaligned;
   assign o_illegal    = w_dec.illegal;

   always_comb begin
      o_rd_data = i_rd_raw;
      if (!i_rd_is_fetch) begin
         case (i_rd_funct3)
            F3_LB:   o_rd_data = {{24{i_rd_raw[7]}}, i_rd_raw[7:0]};
            F3_LBU:  o_rd_data = {24'd0, i_rd_raw[7:0]};
            F3_LH:   o_rd_data = {{16{i_rd_raw[15]}}, i_rd_raw[15:0]};
            F3_LHU:  o_rd_data = {16'd0, i_rd_raw[15:0]};
            default: o_rd_data = i_rd_raw;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Turns core fetch/load/store requests into the mem_controller
// start_request/request_done handshake; one response per request.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_fetch,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic        start_request,
   output logic        is_write,
   output logic        is_data_fetch,
   output logic [2:0]  num_bytes,
   output logic [31:0] target_address,
   output logic [31:0] write_value,
   input  logic [31:0] fetched_instruction,
   input  logic [31:0] fetched_data,
   input  logic        request_done
);

   localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_fetch;
   logic             r_is_store;
   logic [2:0]       r_funct3;
   logic             r_start_request;
   logic             r_is_write;
   logic             r_is_data_fetch;
   logic [2:0]       r_num_bytes;
   logic [31:0]      r_target_address;
   logic [31:0]      r_write_value;
   logic             r_resp_valid;
   logic             r_resp_err;
   logic [31:0]      r_resp_data;

   logic [2:0]       w_num_bytes;
   logic             w_misaligned;
   logic             w_illegal;
   logic [31:0]      w_rd_raw;
   logic [31:0]      w_rd_data;

   assign w_rd_raw = r_is_fetch ? fetched_instruction : fetched_data;

   mem_access_align u_align (
      .i_is_fetch    (req_is_fetch),
      .i_is_store    (req_is_store),
      .i_funct3      (req_funct3),
      .i_addr_lo     (req_addr[1:0]),
      .o_num_bytes   (w_num_bytes),
      .o_misaligned  (w_misaligned),
      .o_illegal     (w_illegal),
      .i_rd_is_fetch (r_is_fetch),
      .i_rd_funct3   (r_funct3),
      .i_rd_raw      (w_rd_raw),
      .o_rd_data     (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_is_fetch       <= 1'b0;
         r_is_store       <= 1'b0;
         r_funct3         <= '0;
         r_start_request  <= 1'b0;
         r_is_write       <= 1'b0;
         r_is_data_fetch  <= 1'b0;
         r_num_bytes      <= '0;
         r_target_address <= '0;
         r_write_value    <= '0;
         r_resp_valid     <= 1'b0;
         r_resp_err       <= 1'b0;
         r_resp_data      <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_is_fetch <= req_is_fetch;
                  r_is_store <= req_is_store & ~req_is_fetch;
                  r_funct3   <= req_funct3;
                  if (w_misaligned || w_illegal) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_data  <= '0;
                  end else begin
                     r_state          <= ST_WAIT;
                     r_cnt            <= '0;
                     r_start_request  <= 1'b1;
                     r_is_write       <= req_is_store & ~req_is_fetch;
                     r_is_data_fetch  <= ~req_is_fetch;
                     r_num_bytes      <= w_num_bytes;
                     r_target_address <= req_addr;
                     r_write_value    <= req_wdata;
                  end
               end
            end
            ST_WAIT: begin
               // A completion in the final counted cycle beats the timeout.
               if (request_done) begin
                  r_state         <= ST_RESP;
                  r_start_request <= 1'b0;
                  r_resp_valid    <= 1'b1;
                  r_resp_data     <= r_is_store ? '0 : w_rd_data;
               end else if (r_cnt == CNT_LAST) begin
                  r_state         <= ST_RESP;
                  r_start_request <= 1'b0;
                  r_resp_valid    <= 1'b1;
                  r_resp_err      <= 1'b1;
                  r_resp_data     <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_state     <= ST_GAP;
               r_resp_data <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = (r_state == ST_IDLE);
   assign resp_valid     = r_resp_valid;
   assign resp_err       = r_resp_err;
   assign resp_data      = r_resp_data;
   assign start_request  = r_start_request;
   assign is_write       = r_is_write;
   assign is_data_fetch  = r_is_data_fetch;
   assign num_bytes      = r_num_bytes;
   assign target_address = r_target_address;
   assign write_value    = r_write_value;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level
// timing model, plus directed cases with literal expectations.
module tb_mem_access_unit;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_fetch = 1'b0;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        start_request;
   logic        is_write;
   logic        is_data_fetch;
   logic [2:0]  num_bytes;
   logic [31:0] target_address;
   logic [31:0] write_value;
   logic [31:0] fetched_instruction = '0;
   logic [31:0] fetched_data = '0;
   logic        request_done = 1'b0;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_is_fetch        (req_is_fetch),
      .req_is_store        (req_is_store),
      .req_funct3          (req_funct3),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .resp_valid          (resp_valid),
      .resp_data           (resp_data),
      .resp_err            (resp_err),
      .start_request       (start_request),
      .is_write            (is_write),
      .is_data_fetch       (is_data_fetch),
      .num_bytes           (num_bytes),
      .target_address      (target_address),
      .write_value         (write_value),
      .fetched_instruction (fetched_instruction),
      .fetched_data        (fetched_data),
      .request_done        (request_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Model of the outstanding transaction: accepted in cycle m_t, start
   // high for m_keff cycles, response one cycle later, ready two after that.
   bit          mdl_on = 1'b0;
   bit          m_act = 1'b0;
   int          m_t, m_keff;
   bit          m_legal, m_wr, m_df, m_err;
   logic [2:0]  m_nb;
   logic [31:0] m_addr, m_wdata, m_data;

   int          obs_len;
   bit          obs_rv, obs_err, obs_wr, obs_df;
   logic [2:0]  obs_nb;
   logic [31:0] obs_data, obs_wv;

   function automatic int unsigned size_of(input bit f, input logic [2:0] f3);
      if (f) return 4;
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_illegal(input bit f, input bit st, input logic [2:0] f3);
      if (f) return 1'b0;
      if (st) return f3 >= 3;
      return (f3 == 3) || (f3 >= 6);
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] m);
      case (f3)
         3'd0:    return 32'($signed(m[7:0]));
         3'd4:    return 32'(m[7:0]);
         3'd1:    return 32'($signed(m[15:0]));
         3'd5:    return 32'(m[15:0]);
         default: return m;
      endcase
   endfunction

   int  c_now, c_resp;
   bit  e_start, e_rv, e_rdy;

   always begin
      @(posedge clk);
      #1;
      if (mdl_on) begin
         c_now   = cyc;
         c_resp  = m_t + m_keff + 1;
         e_start = m_act && m_legal && (c_now > m_t) && (c_now <= m_t + m_keff);
         e_rv    = m_act && (c_now == c_resp);
         e_rdy   = !m_act || (c_now <= m_t) || (c_now >= c_resp + 2);
         chk("start_request", 32'(start_request), 32'(e_start));
         chk("resp_valid", 32'(resp_valid), 32'(e_rv));
         chk("req_ready", 32'(req_ready), 32'(e_rdy));
         if (e_start) begin
            chk("is_write", 32'(is_write), 32'(m_wr));
            chk("is_data_fetch", 32'(is_data_fetch), 32'(m_df));
            chk("num_bytes", 32'(num_bytes), 32'(m_nb));
            chk("target_address", target_address, m_addr);
            chk("write_value", write_value, m_wdata);
         end
         if (e_rv) begin
            chk("resp_err", 32'(resp_err), 32'(m_err));
            chk("resp_data", resp_data, m_data);
         end
         if (start_request) begin
            obs_len++;
            obs_nb = num_bytes;
            obs_wr = is_write;
            obs_df = is_data_fetch;
            obs_wv = write_value;
         end
         if (resp_valid) begin
            obs_rv   = 1'b1;
            obs_err  = resp_err;
            obs_data = resp_data;
         end
      end
   end

   task automatic wait_ready();
      int unsigned waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", 32'(req_ready), 32'd1);
   endtask

   // kd: WAIT cycle (1..TO) in which request_done is driven; 0 = never.
   task automatic do_txn(input bit f, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mv, input int unsigned kd);
      int unsigned sz;
      bit          legal;
      int unsigned keff;
      wait_ready();
      if (!req_ready) return;
      sz    = size_of(f, f3);
      legal = !is_illegal(f, st, f3) && ((a % sz) == 0);
      keff  = !legal ? 0 : (kd == 0 ? TO : kd);
      m_t     = cyc;
      m_keff  = int'(keff);
      m_legal = legal;
      m_wr    = !f && st;
      m_df    = !f;
      m_nb    = 3'(sz);
      m_addr  = a;
      m_wdata = wd;
      m_err   = !legal || (kd == 0);
      m_data  = (m_err || m_wr) ? 32'd0 : (f ? mv : extend(f3, mv));
      m_act   = 1'b1;
      obs_len = 0;
      obs_rv  = 1'b0;
      req_valid    = 1'b1;
      req_is_fetch = f;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      request_done = 1'($urandom % 2);
      fetched_instruction = $urandom;
      fetched_data        = $urandom;
      for (int unsigned j = 1; j <= keff + 2; j++) begin
         @(negedge clk);
         req_valid    = 1'($urandom % 2);
         req_is_fetch = 1'($urandom % 2);
         req_is_store = 1'($urandom % 2);
         req_funct3   = 3'($urandom % 8);
         req_addr     = $urandom;
         req_wdata    = $urandom;
         fetched_instruction = $urandom;
         fetched_data        = $urandom;
         if (legal && j <= keff) request_done = (kd != 0) && (j == kd);
         else request_done = 1'($urandom % 2);
         if (legal && kd != 0 && j == kd) begin
            if (f) fetched_instruction = mv;
            else fetched_data = mv;
         end
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         req_valid    = 1'b0;
         request_done = 1'($urandom % 2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_start", 32'(start_request), 32'd0);
      chk("rst_is_write", 32'(is_write), 32'd0);
      chk("rst_is_data_fetch", 32'(is_data_fetch), 32'd0);
      chk("rst_num_bytes", 32'(num_bytes), 32'd0);
      chk("rst_target", target_address, 32'd0);
      chk("rst_write_value", write_value, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      mdl_on = 1'b1;

      do_txn(1'b0, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h0000_0080, 5);
      chk("lb_num_bytes", 32'(obs_nb), 32'd1);
      chk("lb_start_len", 32'(obs_len), 32'd5);
      chk("lb_resp_data", obs_data, 32'hFFFF_FF80);
      chk("lb_resp_err", 32'(obs_err), 32'd0);

      do_txn(1'b0, 1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h0000_8001, 2);
      chk("lhu_num_bytes", 32'(obs_nb), 32'd2);
      chk("lhu_resp_data", obs_data, 32'h0000_8001);

      do_txn(1'b0, 1'b0, 3'd1, 32'h0000_0201, 32'h0, 32'h1234_5678, 1);
      chk("lh_mis_start_len", 32'(obs_len), 32'd0);
      chk("lh_mis_resp_err", 32'(obs_err), 32'd1);
      chk("lh_mis_resp_data", obs_data, 32'd0);

      do_txn(1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3);
      chk("sw_is_write", 32'(obs_wr), 32'd1);
      chk("sw_num_bytes", 32'(obs_nb), 32'd4);
      chk("sw_write_value", obs_wv, 32'hDEAD_BEEF);
      chk("sw_resp_data", obs_data, 32'd0);
      chk("sw_resp_err", 32'(obs_err), 32'd0);

      do_txn(1'b0, 1'b1, 3'd3, 32'h0000_0020, 32'h1, 32'h0, 1);
      chk("st_f3_3_resp_err", 32'(obs_err), 32'd1);

      do_txn(1'b1, 1'b0, 3'd7, 32'h0000_0004, 32'h0, 32'h0000_0013, 1);
      chk("fetch_is_data_fetch", 32'(obs_df), 32'd0);
      chk("fetch_resp_data", obs_data, 32'h0000_0013);
      do_txn(1'b1, 1'b0, 3'd0, 32'h0000_0008, 32'h0, 32'h0000_0093, 1);
      chk("fetch2_resp_data", obs_data, 32'h0000_0093);

      do_txn(1'b0, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 0);
      chk("timeout_start_len", 32'(obs_len), 32'd8);
      chk("timeout_resp_err", 32'(obs_err), 32'd1);
      chk("timeout_resp_data", obs_data, 32'd0);

      do_txn(1'b0, 1'b0, 3'd4, 32'h0000_0041, 32'h0, 32'h0000_00F0, TO);
      chk("last_cycle_done_err", 32'(obs_err), 32'd0);
      chk("last_cycle_done_data", obs_data, 32'h0000_00F0);

      for (int i = 0; i < 120; i++) begin
         a = $urandom;
         if ($urandom % 2 == 0) a[1:0] = 2'b00;
         do_txn(($urandom % 4) == 0, 1'($urandom % 2), 3'($urandom % 8), a,
                $urandom, $urandom, $urandom % (TO + 1));
         if ($urandom % 4 == 0) idle($urandom % 3);
      end

      // Reset three cycles into WAIT aborts the request without a response.
      wait_ready();
      mdl_on = 1'b0;
      m_act  = 1'b0;
      req_valid    = 1'b1;
      req_is_fetch = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'd2;
      req_addr     = 32'h0000_0100;
      request_done = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_start_before", 32'(start_request), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_start_after", 32'(start_request), 32'd0);
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
         chk("rst_mid_ready", 32'(req_ready), 32'd1);
      end

      mdl_on = 1'b1;
      do_txn(1'b0, 1'b0, 3'd0, 32'h0000_0003, 32'h0, 32'h0000_007F, 1);
      chk("post_rst_lb_data", obs_data, 32'h0000_007F);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
